pc_redirect_sequencer: RTL and testbench

- Owns the architectural fetch PC for the five-stage pipeline.
- Sequences instruction fetch through a valid/ready handshake to instruction memory.
- Consumes the EX-stage 2-bit branch decision (0 = PC+4, 1 = PC+imm, 2 = ALU result) and generates the flush and stall controls for the IF/ID and ID/EX pipeline registers.
- Detects misaligned control-flow targets and halts fetch until reset.

---
 rtl/pc_redirect_sequencer_pkg.sv | 21 ++
 rtl/pc_redirect_sequencer_target_gen.sv | 37 +++
 rtl/pc_redirect_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_redirect_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pc_redirect_sequencer_pkg.sv
// rtl/pc_redirect_sequencer_pkg.sv - shared encodings for the fetch PC sequencer
package pc_redirect_sequencer_pkg;

    // EX-stage branch decision encodings (3 is reserved and behaves as BC_SEQ)
    localparam logic [1:0] BC_SEQ = 2'd0;
    localparam logic [1:0] BC_IMM = 2'd1;
    localparam logic [1:0] BC_ALU = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Control-flow opcodes, shared with the branch/jump decode logic
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_redirect_sequencer_target_gen.sv
// rtl/pc_redirect_sequencer_target_gen.sv - redirect target selection and alignment check
module pc_target_gen
    import pc_redirect_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      branch_ctrl,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            is_ctrl,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    // Pick the target for the decision; JALR targets drop bit 0 before use
    always_comb begin
        is_ctrl = 1'b0;
        target  = '0;
        case (branch_ctrl)
            BC_IMM: begin
                is_ctrl = 1'b1;
                target  = ex_pc + ex_imm;
            end
            BC_ALU: begin
                is_ctrl = 1'b1;
                target  = alu_result & ~XLEN'(1);
            end
            default: begin
                is_ctrl = 1'b0;
                target  = '0;
            end
        endcase
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_redirect_sequencer.sv
// rtl/pc_redirect_sequencer.sv - fetch PC owner with redirect, stall, flush and fault control
module pc_redirect_sequencer
    import pc_redirect_sequencer_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branch_ctrl,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             load_use_stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [XLEN-1:0]  pc_out,
    output logic             if_valid,
    output logic             stall_if,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misaligned_fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] redirect_count
);

    seq_state_t       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_ctrl;
    logic             misaligned;
    logic [XLEN-1:0]  target;
    logic             redirect;

    pc_target_gen #(.XLEN(XLEN)) u_target_gen (
        .branch_ctrl (branch_ctrl),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .alu_result  (alu_result),
        .is_ctrl     (is_ctrl),
        .target      (target),
        .misaligned  (misaligned)
    );

    assign redirect = ex_valid && is_ctrl && (state_q == RUN);

    // Next-state and pipeline controls; a redirect overrides stalls and memory waits
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        cnt_d        = cnt_q;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        stall_if     = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (misaligned) begin
                        state_d      = FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = target;
                    end else begin
                        pc_d  = target;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    imem_req = 1'b1;
                    if (load_use_stall) begin
                        stall_if = 1'b1;
                    end else if (imem_ready) begin
                        pc_d     = pc_q + XLEN'(4);
                        if_valid = 1'b1;
                    end else begin
                        stall_if = 1'b1;
                    end
                end
            end
            FAULT: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Reset cycle drives every combinational control low
        if (rst) begin
            imem_req    = 1'b0;
            if_valid    = 1'b0;
            stall_if    = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    // State, PC, fault and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= XLEN'(RESET_PC);
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pc_out           = pc_q;
    assign misaligned_fault = fault_q;
    assign fault_addr       = fault_addr_q;
    assign redirect_count   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// tb/tb_pc_redirect_sequencer.sv - vector and scoreboard bench for pc_redirect_sequencer
module tb_pc_redirect_sequencer;

    typedef struct {
        logic        rst;
        logic        exv;
        logic [1:0]  bc;
        logic [31:0] expc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        lus;
        logic        rdy;
        logic        req;
        logic        ifv;
        logic        stall;
        logic        fl;
        logic [31:0] npc;
        logic        nf;
        logic [31:0] nfa;
        logic [15:0] ncnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        f;
        logic [31:0] fa;
        logic [15:0] cnt;
    } post_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  branch_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, alu_result;
    logic        load_use_stall, imem_ready;
    logic        imem_req, if_valid, stall_if, flush_if_id, flush_id_ex, misaligned_fault;
    logic [31:0] pc_out, fault_addr;
    logic [15:0] redirect_count;

    int n_pass = 0;
    int n_total = 0;
    vec_t  vecs[$];
    post_t sb[$];

    always #5 clk = ~clk;

    pc_redirect_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .branch_ctrl      (branch_ctrl),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .alu_result       (alu_result),
        .load_use_stall   (load_use_stall),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .pc_out           (pc_out),
        .if_valid         (if_valid),
        .stall_if         (stall_if),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .misaligned_fault (misaligned_fault),
        .fault_addr       (fault_addr),
        .redirect_count   (redirect_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic ev, input logic [1:0] b,
                                input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                                input logic l, input logic rd, input logic q, input logic iv,
                                input logic st, input logic f, input logic [31:0] np,
                                input logic nf, input logic [31:0] nfa, input logic [15:0] nc);
        vec_t v;
        v.rst = r; v.exv = ev; v.bc = b; v.expc = p; v.imm = im; v.alu = a;
        v.lus = l; v.rdy = rd; v.req = q; v.ifv = iv; v.stall = st; v.fl = f;
        v.npc = np; v.nf = nf; v.nfa = nfa; v.ncnt = nc;
        return v;
    endfunction

    // Drive one vector, check combinational controls mid-cycle, then check registers after the edge
    task automatic apply(input vec_t v, input int idx);
        post_t e, g;
        rst = v.rst; ex_valid = v.exv; branch_ctrl = v.bc; ex_pc = v.expc;
        ex_imm = v.imm; alu_result = v.alu; load_use_stall = v.lus; imem_ready = v.rdy;
        @(negedge clk);
        chk($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(v.req));
        chk($sformatf("v%0d if_valid", idx), 32'(if_valid), 32'(v.ifv));
        chk($sformatf("v%0d stall_if", idx), 32'(stall_if), 32'(v.stall));
        chk($sformatf("v%0d flush_if_id", idx), 32'(flush_if_id), 32'(v.fl));
        chk($sformatf("v%0d flush_id_ex", idx), 32'(flush_id_ex), 32'(v.fl));
        e.pc = v.npc; e.f = v.nf; e.fa = v.nfa; e.cnt = v.ncnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard", idx), 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk($sformatf("v%0d pc_out", idx), pc_out, g.pc);
            chk($sformatf("v%0d misaligned_fault", idx), 32'(misaligned_fault), 32'(g.f));
            chk($sformatf("v%0d fault_addr", idx), fault_addr, g.fa);
            chk($sformatf("v%0d redirect_count", idx), 32'(redirect_count), 32'(g.cnt));
        end
    endtask

    initial begin
        vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,0,0,0, 32'h0,0,0,0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,1,0,0, 32'(4*i),0,0,0));
        vecs.push_back(mk(0,1,2'd1,32'h18,32'h40,0,0,1, 0,0,0,1, 32'h58,0,0,1));
        vecs.push_back(mk(0,1,2'd1,32'h30,32'h0,0,0,1, 0,0,0,1, 32'h30,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0,1,1, 1,0,1,0, 32'h30,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0,1,1, 1,0,1,0, 32'h30,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,1,0,0, 32'h34,0,0,2));
        vecs.push_back(mk(0,1,2'd1,32'h80,32'h0,0,1,1, 0,0,0,1, 32'h80,0,0,3));
        vecs.push_back(mk(0,1,2'd2,0,0,32'h41,0,1, 0,0,0,1, 32'h40,0,0,4));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0, 32'h40,0,0,4));
        vecs.push_back(mk(0,1,2'd1,32'hF0,32'h10,0,0,0, 0,0,0,1, 32'h100,0,0,5));
        vecs.push_back(mk(0,0,2'd1,0,32'h200,0,0,1, 1,1,0,0, 32'h104,0,0,5));
        vecs.push_back(mk(0,1,2'd3,0,32'h200,0,0,1, 1,1,0,0, 32'h108,0,0,5));
        vecs.push_back(mk(0,1,2'd1,32'hFFFF_FFF8,32'h10,0,0,1, 0,0,0,1, 32'h8,0,0,6));
        vecs.push_back(mk(0,1,2'd2,0,0,32'h1001,0,1, 0,0,0,1, 32'h1000,0,0,7));
        vecs.push_back(mk(0,1,2'd2,0,0,32'h1003,0,1, 0,0,0,1, 32'h1000,1,32'h1002,7));
        vecs.push_back(mk(0,1,2'd1,32'h80,0,0,0,1, 0,0,0,1, 32'h1000,1,32'h1002,7));
        vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,1, 32'h1000,1,32'h1002,7));
        vecs.push_back(mk(1,1,2'd1,32'h80,0,0,0,1, 0,0,0,0, 32'h0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,1,0,0, 32'h4,0,0,0));

        rst = 1'b1; ex_valid = 1'b0; branch_ctrl = 2'd0; ex_pc = '0; ex_imm = '0;
        alu_result = '0; load_use_stall = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Counter wrap: 65535 back-to-back redirects to address 0, then one more
        ex_valid = 1'b1; branch_ctrl = 2'd1; ex_pc = 32'h0; ex_imm = 32'h0;
        load_use_stall = 1'b0; imem_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("count_at_max", 32'(redirect_count), 32'h0000_FFFF);
        chk("pc_after_loop", pc_out, 32'h0);
        apply(mk(0,1,2'd1,32'h0,32'h0,0,0,1, 0,0,0,1, 32'h0,0,0,16'h0000), 100);
        // Misaligned PC+imm target also faults
        apply(mk(0,1,2'd1,32'h4,32'h2,0,0,1, 0,0,0,1, 32'h0,1,32'h6,16'h0000), 101);
        apply(mk(0,0,0,0,0,0,0,1, 0,0,0,1, 32'h0,1,32'h6,16'h0000), 102);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
